// File: rtl/bus_pkg.sv
// Shared definitions for the CPU IO bus router: read-source select and wait FSM states.
package bus_pkg;

  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_IO  = 2'd1,
    SRC_DEV = 2'd2
  } bus_src_e;

  typedef enum logic {
    WS_IDLE = 1'b0,
    WS_WAIT = 1'b1
  } wait_state_e;

  localparam logic [19:0] IO_PORT_ADDR_DEFAULT = 20'h0BFFC;

endpackage

// File: rtl/bus_wait_ctrl.sv
// Wait-state controller: stalls the CPU for wait_n cycles when a waited device is first hit.
module bus_wait_ctrl
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] wait_n,
  input  logic       ready,
  output logic       fsm_ready
);

  wait_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // fsm_ready is kept apart from next-state so the ready feedback forms no loop.
  always_comb begin
    fsm_ready = 1'b1;
    case (state_q)
      WS_IDLE: fsm_ready = ~start;
      WS_WAIT: fsm_ready = (cnt_q == '0);
      default: fsm_ready = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WS_IDLE: begin
        if (start) begin
          state_d = WS_WAIT;
          cnt_d   = wait_n - 4'd1;
        end
      end
      WS_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (ready) begin
          state_d = WS_IDLE;
        end
      end
      default: state_d = WS_IDLE;
    endcase
  end

endmodule

// File: rtl/io_bus_router.sv
// CPU bus address decoder / read mux with IO port register and device wait states.
// Optional macro BUS_STRESS_READY_EN: ready is only allowed on alternate cycles.
module io_bus_router
  import bus_pkg::*;
#(
  parameter int unsigned                 ADDR_W       = 20,
  parameter int unsigned                 NUM_DEV      = 2,
  parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_BASE     = {20'h0D640, 20'h0D000},
  parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_MASK     = {20'hFFFC0, 20'hFFF00},
  parameter logic [NUM_DEV*4-1:0]        DEV_WAIT     = {4'd0, 4'd2},
  parameter logic [ADDR_W-1:0]           IO_PORT_ADDR = IO_PORT_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    cpu_address_next,
  input  logic                 cpu_write_next,
  input  logic [7:0]           cpu_data_out,
  input  logic                 mapper_busy,
  input  logic [7:0]           mem_data_i,
  input  logic [8*NUM_DEV-1:0] dev_data_i,
  output logic [7:0]           cpu_data_in,
  output logic                 ready,
  output logic                 mem_we,
  output logic [NUM_DEV-1:0]   dev_cs,
  output logic                 dev_we,
  output logic [7:0]           io_port,
  output logic                 irq,
  output logic                 nmi
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  logic             io_hit, dev_any, mem_hit, dev_start, fsm_ready, stress_ok;
  logic [IDX_W-1:0] hit_idx;
  logic [3:0]       wait_n;
  bus_src_e         sel_q, sel_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [7:0]       io_port_q, io_port_d;

  // IO port beats every device; among devices the lowest index wins.
  always_comb begin
    io_hit  = (cpu_address_next == IO_PORT_ADDR);
    dev_any = 1'b0;
    dev_cs  = '0;
    hit_idx = '0;
    wait_n  = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!io_hit && !dev_any &&
          ((cpu_address_next & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W])) begin
        dev_any   = 1'b1;
        dev_cs[i] = 1'b1;
        hit_idx   = IDX_W'(i);
        wait_n    = DEV_WAIT[i*4 +: 4];
      end
    end
    mem_hit   = ~io_hit & ~dev_any;
    dev_start = dev_any & (wait_n != '0);
  end

`ifdef BUS_STRESS_READY_EN
  logic stress_phase_q, stress_phase_d;

  always_comb stress_phase_d = ~stress_phase_q;

  always_ff @(posedge clk) begin
    if (reset) stress_phase_q <= 1'b0;
    else       stress_phase_q <= stress_phase_d;
  end

  assign stress_ok = ~stress_phase_q;
`else
  assign stress_ok = 1'b1;
`endif

  bus_wait_ctrl u_wait (
    .clk       (clk),
    .reset     (reset),
    .start     (dev_start),
    .wait_n    (wait_n),
    .ready     (ready),
    .fsm_ready (fsm_ready)
  );

  assign ready = fsm_ready & ~mapper_busy & stress_ok & ~reset;

  always_comb begin
    sel_d     = sel_q;
    sel_idx_d = sel_idx_q;
    io_port_d = io_port_q;
    if (ready) begin
      sel_d     = io_hit ? SRC_IO : (dev_any ? SRC_DEV : SRC_MEM);
      sel_idx_d = hit_idx;
      if (io_hit && cpu_write_next) io_port_d = cpu_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= SRC_MEM;
      sel_idx_q <= '0;
      io_port_q <= '0;
    end else begin
      sel_q     <= sel_d;
      sel_idx_q <= sel_idx_d;
      io_port_q <= io_port_d;
    end
  end

  always_comb begin
    cpu_data_in = mem_data_i;
    case (sel_q)
      SRC_IO:  cpu_data_in = io_port_q;
      SRC_DEV: begin
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
          if (sel_idx_q == IDX_W'(i)) cpu_data_in = dev_data_i[i*8 +: 8];
        end
      end
      default: cpu_data_in = mem_data_i;
    endcase
  end

  assign mem_we  = cpu_write_next & ready & mem_hit;
  assign dev_we  = cpu_write_next & ready & dev_any;
  assign io_port = io_port_q;
  assign irq     = io_port_q[0];
  assign nmi     = io_port_q[1];

endmodule

// File: tb/tb_io_bus_router.sv
// Self-checking bench for io_bus_router: directed scenarios plus random traffic vs. a behavioural model.
module tb_io_bus_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] addr;
  logic        wr;
  logic [7:0]  wdata;
  logic        busy;
  logic [7:0]  mem_data;
  logic [15:0] dev_data;

  logic [7:0]  cpu_data_in;
  logic        ready, mem_we, dev_we, irq, nmi;
  logic [1:0]  dev_cs;
  logic [7:0]  io_port;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [19:0] T_BASE [2] = '{20'h0D000, 20'h0D640};
  localparam logic [19:0] T_MASK [2] = '{20'hFFF00, 20'hFFFC0};
  localparam int          T_WAIT [2] = '{2, 0};

  // Model state: target codes are 0 = memory, 1 = IO port, 2+i = device i.
  int         m_src, m_dec, m_elapsed, m_need, m_k;
  bit         m_acc;
  logic [7:0] m_io;

  logic       e_ready, e_mem_we, e_dev_we;
  logic [1:0] e_cs;
  logic [7:0] e_data;
  logic       obs_ready, obs_mem_we, obs_dev_we;
  logic [1:0] obs_cs;

  io_bus_router dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_address_next (addr),
    .cpu_write_next   (wr),
    .cpu_data_out     (wdata),
    .mapper_busy      (busy),
    .mem_data_i       (mem_data),
    .dev_data_i       (dev_data),
    .cpu_data_in      (cpu_data_in),
    .ready            (ready),
    .mem_we           (mem_we),
    .dev_cs           (dev_cs),
    .dev_we           (dev_we),
    .io_port          (io_port),
    .irq              (irq),
    .nmi              (nmi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [19:0] a);
    if (a == 20'h0BFFC) return 1;
    for (int i = 0; i < 2; i++)
      if ((a & T_MASK[i]) == T_BASE[i]) return 2 + i;
    return 0;
  endfunction

  task automatic model_comb();
    bit ok, st;
    m_dec = decode(addr);
    if (m_acc) ok = (m_elapsed >= m_need);
    else       ok = !(m_dec >= 2 && T_WAIT[m_dec-2] > 0);
`ifdef BUS_STRESS_READY_EN
    st = (m_k % 2 == 0);
`else
    st = 1'b1;
`endif
    e_ready  = ok && !busy && st && !reset;
    e_cs     = (m_dec >= 2) ? 2'(1 << (m_dec - 2)) : 2'b00;
    e_mem_we = wr && e_ready && (m_dec == 0);
    e_dev_we = wr && e_ready && (m_dec >= 2);
    if (m_src == 0)      e_data = mem_data;
    else if (m_src == 1) e_data = m_io;
    else                 e_data = dev_data[(m_src-2)*8 +: 8];
  endtask

  task automatic model_seq();
    if (reset) begin
      m_io = '0; m_src = 0; m_acc = 0; m_elapsed = 0; m_k = 0;
    end else begin
      m_k++;
      if (m_acc) begin
        if (e_ready) m_acc = 0;
        else         m_elapsed++;
      end else if (m_dec >= 2 && T_WAIT[m_dec-2] > 0) begin
        m_acc = 1; m_elapsed = 1; m_need = T_WAIT[m_dec-2];
      end
      if (e_ready) begin
        m_src = m_dec;
        if (m_dec == 1 && wr) m_io = wdata;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_comb();
    chk("ready",       32'(ready),       32'(e_ready));
    chk("cpu_data_in", 32'(cpu_data_in), 32'(e_data));
    chk("mem_we",      32'(mem_we),      32'(e_mem_we));
    chk("dev_we",      32'(dev_we),      32'(e_dev_we));
    chk("dev_cs",      32'(dev_cs),      32'(e_cs));
    chk("io_port",     32'(io_port),     32'(m_io));
    chk("irq",         32'(irq),         32'(m_io[0]));
    chk("nmi",         32'(nmi),         32'(m_io[1]));
    obs_ready = ready; obs_mem_we = mem_we; obs_dev_we = dev_we; obs_cs = dev_cs;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  initial begin
    int stalls, highs;
    bit done;
    m_src = 0; m_acc = 0; m_elapsed = 0; m_need = 0; m_k = 0; m_io = '0; m_dec = 0;
    reset = 1'b1; addr = 20'h01000; wr = 1'b0; wdata = '0; busy = 1'b0;
    mem_data = 8'h3C; dev_data = 16'h5AA5;
    tick(); tick();
    chk("reset_ready", 32'(obs_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_io", 32'(io_port), 32'h0);

`ifndef BUS_STRESS_READY_EN
    // IO port write
    addr = 20'h0BFFC; wr = 1'b1; wdata = 8'h03;
    tick();
    chk("io_wr_mem_we", 32'(obs_mem_we), 32'd0);
    chk("io_wr_port", 32'({io_port, irq, nmi}), 32'({8'h03, 1'b1, 1'b1}));
    addr = 20'h00200; wr = 1'b0;
    tick();

    // Device 0 read with two wait states
    addr = 20'h0D000; dev_data = 16'h77A5; stalls = 0; done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      if (obs_ready) done = 1; else stalls++;
    end
    chk("dev0_stalls", 32'(stalls), 32'd2);
    chk("dev0_rdata", 32'(cpu_data_in), 32'h0A5);
    addr = 20'h00300;
    tick();

    // Device 1: zero wait, strobe only on writes
    addr = 20'h0D640; wr = 1'b0;
    tick();
    chk("dev1_cs", 32'(obs_cs), 32'h2);
    chk("dev1_ready", 32'(obs_ready), 32'd1);
    chk("dev1_we_rd", 32'(obs_dev_we), 32'd0);
    wr = 1'b1;
    tick();
    chk("dev1_we_wr", 32'(obs_dev_we), 32'd1);
    wr = 1'b0; addr = 20'h00400;
    tick();

    // mapper_busy with wait counter exhausted
    addr = 20'h0D010; highs = 0;
    tick(); highs += int'(obs_ready);
    tick(); highs += int'(obs_ready);
    busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("busy_hold", 32'(obs_ready), 32'd0);
    end
    busy = 1'b0;
    tick(); highs += int'(obs_ready);
    chk("busy_single_done", 32'(highs), 32'd1);

    // Back-to-back waited accesses
    highs = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); highs += int'(obs_ready);
    end
    chk("b2b_completions", 32'(highs), 32'd2);
    addr = 20'h00500;
    tick();

    // Reset mid-wait
    addr = 20'h0BFFC; wr = 1'b1; wdata = 8'h55;
    tick();
    addr = 20'h0D000;
    tick();
    chk("rst_wait_entry", 32'(obs_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_no_strobe", 32'({obs_mem_we, obs_dev_we, obs_ready}), 32'd0);
    reset = 1'b0; addr = 20'h01234; wr = 1'b0;
    tick();
    chk("rst_idle", 32'(obs_ready), 32'd1);
    chk("rst_io_clr", 32'(io_port), 32'h0);
`else
    // Alternate-cycle ready: a two-cycle write request lands once
    reset = 1'b1;
    tick();
    reset = 1'b0; addr = 20'h01234; wr = 1'b1; wdata = 8'h9E; highs = 0;
    tick(); highs += int'(obs_mem_we);
    tick(); highs += int'(obs_mem_we);
    chk("stress_single_we", 32'(highs), 32'd1);
    wr = 1'b0;
    tick();
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 0 || $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       addr = 20'h0BFFC;
          1:       addr = 20'h0D000 | 20'($urandom_range(0, 255));
          2:       addr = 20'h0D640 | 20'($urandom_range(0, 63));
          3:       addr = 20'h0D600 | 20'($urandom_range(0, 63));
          default: addr = 20'($urandom);
        endcase
      end
      wr       = 1'($urandom_range(0, 1));
      wdata    = 8'($urandom);
      busy     = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      mem_data = 8'($urandom);
      dev_data = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
